// File: rtl/axi4_defs_pkg.sv
// Shared AXI4 burst/response encodings and FSM state types for the block-RAM slave.
// Optional WRAP support is enabled by defining AXI_SLAVE_WRAP_BURST_EN.
package axi4_defs_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // A decode error outranks a slave error when both occur in one burst.
  function automatic logic [1:0] merge_resp(input logic decerr, input logic slverr);
    if (decerr) return AXI_RESP_DECERR;
    if (slverr) return AXI_RESP_SLVERR;
    return AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_slave_ram_core.sv
// Byte-enabled simple dual-port RAM: one write port, one registered read port.
// Each byte lane is its own array so the lanes map cleanly onto block RAM.
module axi4_slave_ram_core
  import axi4_defs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                clk_in,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                re,
  input  logic [IDX_W-1:0]    raddr,
  output logic [DATA_W-1:0]   rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_q_reg;

      // Read-before-write: a same-cycle read of the written word sees the old byte.
      always_ff @(posedge clk_in) begin
        if (we && wstrb[gi]) lane_mem[waddr] <= wdata[gi*8 +: 8];
        if (re) lane_q_reg <= lane_mem[raddr];
      end

      assign rdata[gi*8 +: 8] = lane_q_reg;
    end
  endgenerate

endmodule

// File: rtl/axi4_slave_block_ram.sv
// AXI4 INCR burst slave backed by on-chip RAM; independent read and write FSMs.
// Define AXI_SLAVE_WRAP_BURST_EN to honour WRAP bursts (otherwise WRAP acts as INCR).
module axi4_slave_block_ram
  import axi4_defs_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 4,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int MEM_DEPTH_IN_WORDS = 1024,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_S_TARGET_BASE_ADDR = '0
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                        S_AXI_AWLEN,
  input  logic [1:0]                        S_AXI_AWBURST,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WLAST,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                        S_AXI_ARLEN,
  input  logic [1:0]                        S_AXI_ARBURST,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RLAST,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);

  localparam int A      = C_S_AXI_ADDR_WIDTH;
  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int IW     = C_S_AXI_ID_WIDTH;
  localparam int BYTES  = DW / 8;
  localparam int LSB    = $clog2(BYTES);
  localparam int IDX_W  = $clog2(MEM_DEPTH_IN_WORDS);
  localparam logic [A:0]   SPAN       = (A+1)'(MEM_DEPTH_IN_WORDS) << LSB;
  localparam logic [A-1:0] BEAT_BYTES = A'(BYTES);

  function automatic logic [A-1:0] next_addr(input logic [A-1:0] addr, input logic wrap,
                                             input logic [A-1:0] mask);
    logic [A-1:0] incr;
    incr = addr + BEAT_BYTES;
    return wrap ? ((addr & ~mask) | (incr & mask)) : incr;
  endfunction

  logic         aw_wrap, ar_wrap, aw_bad, ar_bad;
  logic [A-1:0] aw_mask, ar_mask;

`ifdef AXI_SLAVE_WRAP_BURST_EN
  function automatic logic [A-1:0] wrap_mask(input logic [7:0] len);
    return ((A'(len) + A'(1)) << LSB) - A'(1);
  endfunction

  assign aw_wrap = (S_AXI_AWBURST == AXI_BURST_WRAP);
  assign ar_wrap = (S_AXI_ARBURST == AXI_BURST_WRAP);
  assign aw_mask = wrap_mask(S_AXI_AWLEN);
  assign ar_mask = wrap_mask(S_AXI_ARLEN);
  assign aw_bad  = aw_wrap && (!wrap_len_ok(S_AXI_AWLEN) || (S_AXI_AWADDR[LSB-1:0] != '0));
  assign ar_bad  = ar_wrap && (!wrap_len_ok(S_AXI_ARLEN) || (S_AXI_ARADDR[LSB-1:0] != '0));
`else
  logic unused_burst;
  assign unused_burst = ^{S_AXI_AWBURST, S_AXI_ARBURST};
  assign aw_wrap = 1'b0;
  assign ar_wrap = 1'b0;
  assign aw_mask = '0;
  assign ar_mask = '0;
  assign aw_bad  = 1'b0;
  assign ar_bad  = 1'b0;
`endif

  // ---------------- write channel ----------------
  wr_state_t     wr_state_reg;
  logic          awready_reg, wready_reg, bvalid_reg;
  logic [1:0]    bresp_reg;
  logic [IW-1:0] bid_reg;
  logic [A-1:0]  wr_addr_reg, wr_mask_reg;
  logic [7:0]    wr_len_reg, wr_cnt_reg;
  logic          wr_wrap_reg, wr_slverr_reg, wr_decerr_reg;

  logic [A-1:0]     wr_off;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_hit, w_fire, wr_beat_last, wr_slverr_next, wr_decerr_next, ram_we;

  assign wr_off         = wr_addr_reg - C_S_TARGET_BASE_ADDR;
  assign wr_idx         = wr_off[LSB +: IDX_W];
  assign wr_hit         = ({1'b0, wr_off} < SPAN);
  assign w_fire         = S_AXI_WVALID && wready_reg;
  assign wr_beat_last   = (wr_cnt_reg == wr_len_reg);
  assign wr_slverr_next = wr_slverr_reg || (S_AXI_WLAST != wr_beat_last);
  assign wr_decerr_next = wr_decerr_reg || !wr_hit;
  assign ram_we         = w_fire && wr_hit;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state_reg  <= W_IDLE;
      awready_reg   <= 1'b0;
      wready_reg    <= 1'b0;
      bvalid_reg    <= 1'b0;
      bresp_reg     <= AXI_RESP_OKAY;
      bid_reg       <= '0;
      wr_addr_reg   <= '0;
      wr_mask_reg   <= '0;
      wr_len_reg    <= '0;
      wr_cnt_reg    <= '0;
      wr_wrap_reg   <= 1'b0;
      wr_slverr_reg <= 1'b0;
      wr_decerr_reg <= 1'b0;
    end else begin
      case (wr_state_reg)
        W_IDLE: begin
          awready_reg <= 1'b1;
          if (S_AXI_AWVALID && awready_reg) begin
            awready_reg   <= 1'b0;
            wready_reg    <= 1'b1;
            bid_reg       <= S_AXI_AWID;
            wr_addr_reg   <= S_AXI_AWADDR;
            wr_len_reg    <= S_AXI_AWLEN;
            wr_wrap_reg   <= aw_wrap;
            wr_mask_reg   <= aw_mask;
            wr_cnt_reg    <= '0;
            wr_slverr_reg <= aw_bad;
            wr_decerr_reg <= 1'b0;
            wr_state_reg  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            wr_addr_reg   <= next_addr(wr_addr_reg, wr_wrap_reg, wr_mask_reg);
            wr_cnt_reg    <= wr_cnt_reg + 8'd1;
            wr_slverr_reg <= wr_slverr_next;
            wr_decerr_reg <= wr_decerr_next;
            // AWLEN, not WLAST, decides where the burst ends.
            if (wr_beat_last) begin
              wready_reg   <= 1'b0;
              bvalid_reg   <= 1'b1;
              bresp_reg    <= merge_resp(wr_decerr_next, wr_slverr_next);
              wr_state_reg <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_reg   <= 1'b0;
            awready_reg  <= 1'b1;
            wr_state_reg <= W_IDLE;
          end
        end
        default: wr_state_reg <= W_IDLE;
      endcase
    end
  end

  // ---------------- read channel ----------------
  rd_state_t     rd_state_reg;
  logic          arready_reg, rd_issue_done_reg, rd_wrap_reg, rd_slverr_reg;
  logic [IW-1:0] rid_reg;
  logic [A-1:0]  rd_addr_reg, rd_mask_reg;
  logic [7:0]    rd_len_reg, rd_cnt_reg;
  logic          s1_valid_reg, s1_decerr_reg, s1_last_reg;
  logic          rvalid_reg, rlast_reg;
  logic [DW-1:0] rdata_reg;
  logic [1:0]    rresp_reg;

  logic [A-1:0]     rd_off;
  logic [IDX_W-1:0] rd_idx;
  logic [DW-1:0]    ram_rdata;
  logic             rd_hit, r_fire, s2_load, rd_issue;

  // Stage 1 is the RAM output register; stage 2 is the R channel register.
  assign rd_off   = rd_addr_reg - C_S_TARGET_BASE_ADDR;
  assign rd_idx   = rd_off[LSB +: IDX_W];
  assign rd_hit   = ({1'b0, rd_off} < SPAN);
  assign r_fire   = rvalid_reg && S_AXI_RREADY;
  assign s2_load  = s1_valid_reg && (!rvalid_reg || S_AXI_RREADY);
  assign rd_issue = (rd_state_reg == R_DATA) && !rd_issue_done_reg && (!s1_valid_reg || s2_load);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state_reg      <= R_IDLE;
      arready_reg       <= 1'b0;
      rid_reg           <= '0;
      rd_addr_reg       <= '0;
      rd_mask_reg       <= '0;
      rd_len_reg        <= '0;
      rd_cnt_reg        <= '0;
      rd_issue_done_reg <= 1'b0;
      rd_wrap_reg       <= 1'b0;
      rd_slverr_reg     <= 1'b0;
      s1_valid_reg      <= 1'b0;
      s1_decerr_reg     <= 1'b0;
      s1_last_reg       <= 1'b0;
      rvalid_reg        <= 1'b0;
      rlast_reg         <= 1'b0;
      rdata_reg         <= '0;
      rresp_reg         <= AXI_RESP_OKAY;
    end else begin
      case (rd_state_reg)
        R_IDLE: begin
          arready_reg <= 1'b1;
          if (S_AXI_ARVALID && arready_reg) begin
            arready_reg       <= 1'b0;
            rid_reg           <= S_AXI_ARID;
            rd_addr_reg       <= S_AXI_ARADDR;
            rd_len_reg        <= S_AXI_ARLEN;
            rd_wrap_reg       <= ar_wrap;
            rd_mask_reg       <= ar_mask;
            rd_slverr_reg     <= ar_bad;
            rd_cnt_reg        <= '0;
            rd_issue_done_reg <= 1'b0;
            rd_state_reg      <= R_DATA;
          end
        end
        R_DATA: begin
          if (rd_issue) begin
            rd_addr_reg   <= next_addr(rd_addr_reg, rd_wrap_reg, rd_mask_reg);
            rd_cnt_reg    <= rd_cnt_reg + 8'd1;
            s1_valid_reg  <= 1'b1;
            s1_decerr_reg <= !rd_hit;
            s1_last_reg   <= (rd_cnt_reg == rd_len_reg);
            if (rd_cnt_reg == rd_len_reg) rd_issue_done_reg <= 1'b1;
          end else if (s2_load) begin
            s1_valid_reg <= 1'b0;
          end

          if (s2_load) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= s1_decerr_reg ? '0 : ram_rdata;
            rresp_reg  <= merge_resp(s1_decerr_reg, rd_slverr_reg);
            rlast_reg  <= s1_last_reg;
          end else if (r_fire) begin
            rvalid_reg <= 1'b0;
            rlast_reg  <= 1'b0;
          end

          if (r_fire && rlast_reg) begin
            arready_reg  <= 1'b1;
            rd_state_reg <= R_IDLE;
          end
        end
        default: rd_state_reg <= R_IDLE;
      endcase
    end
  end

  axi4_slave_ram_core #(
    .DATA_W (DW),
    .DEPTH  (MEM_DEPTH_IN_WORDS),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk_in (S_AXI_ACLK),
    .we     (ram_we),
    .waddr  (wr_idx),
    .wdata  (S_AXI_WDATA),
    .wstrb  (S_AXI_WSTRB),
    .re     (rd_issue),
    .raddr  (rd_idx),
    .rdata  (ram_rdata)
  );

  assign S_AXI_AWREADY = awready_reg;
  assign S_AXI_WREADY  = wready_reg;
  assign S_AXI_BID     = bid_reg;
  assign S_AXI_BRESP   = bresp_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_ARREADY = arready_reg;
  assign S_AXI_RID     = rid_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign S_AXI_RRESP   = rresp_reg;
  assign S_AXI_RLAST   = rlast_reg;
  assign S_AXI_RVALID  = rvalid_reg;

endmodule

// File: tb/tb_axi4_slave_block_ram.sv
// Scoreboard bench for axi4_slave_block_ram: directed bursts push expected B/R
// responses; a negedge monitor pops and compares them as the DUT presents them.
module tb_axi4_slave_block_ram;
  import axi4_defs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  axi4_slave_block_ram dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWBURST(awburst),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARBURST(arburst),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} rbeat_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp;} bexp_t;

  rbeat_t rq[$];
  bexp_t  bq[$];
  rbeat_t r_exp, r_got;
  bexp_t  b_exp, b_got;
  int     checks = 0;
  int     fails  = 0;
  int     rmode  = 0;   // 0: RREADY high, 1: toggle each cycle, 2: held low
  logic   held = 1'b0;
  rbeat_t held_beat;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    r_got = '{id: rid, data: rdata, resp: rresp, last: rlast};
    if (held && rvalid) begin
      checks++;
      if (r_got != held_beat) begin
        fails++;
        $display("FAIL r_stable got data=%h resp=%0d last=%0b required data=%h resp=%0d last=%0b",
                 rdata, rresp, rlast, held_beat.data, held_beat.resp, held_beat.last);
      end
    end
    if (rvalid && rready) begin
      checks++;
      if (rq.size() == 0) begin
        fails++;
        $display("FAIL r_unexpected got id=%0h data=%h resp=%0d last=%0b required no beat",
                 rid, rdata, rresp, rlast);
      end else begin
        r_exp = rq.pop_front();
        $display("R  id=%0h data=%h resp=%0d last=%0b", rid, rdata, rresp, rlast);
        if (r_got != r_exp) begin
          fails++;
          $display("FAIL r_beat got id=%0h data=%h resp=%0d last=%0b required id=%0h data=%h resp=%0d last=%0b",
                   rid, rdata, rresp, rlast, r_exp.id, r_exp.data, r_exp.resp, r_exp.last);
        end
      end
    end
    held      = rvalid && !rready;
    held_beat = r_got;

    if (bvalid && bready) begin
      checks++;
      b_got = '{id: bid, resp: bresp};
      if (bq.size() == 0) begin
        fails++;
        $display("FAIL b_unexpected got id=%0h resp=%0d required no response", bid, bresp);
      end else begin
        b_exp = bq.pop_front();
        $display("B  id=%0h resp=%0d", bid, bresp);
        if (b_got != b_exp) begin
          fails++;
          $display("FAIL b_resp got id=%0h resp=%0d required id=%0h resp=%0d",
                   bid, bresp, b_exp.id, b_exp.resp);
        end
      end
    end
  end

  // ---------------- RREADY pattern driver ----------------
  initial begin
    rready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       rready = 1'b1;
        1:       rready = ~rready;
        default: rready = 1'b0;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    fails++;
    $display("FAIL %s got timeout required handshake", name);
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [1:0] burst);
    int n = 0;
    logic hs = 1'b0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    while (!hs) begin
      @(negedge clk); hs = awready;
      @(posedge clk); #1;
      n++;
      if (!hs && n > 50) begin timeout_fail("aw_handshake"); break; end
    end
    awvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [1:0] burst);
    int n = 0;
    logic hs = 1'b0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    while (!hs) begin
      @(negedge clk); hs = arready;
      @(posedge clk); #1;
      n++;
      if (!hs && n > 50) begin timeout_fail("ar_handshake"); break; end
    end
    arvalid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    logic hs = 1'b0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (!hs) begin
      @(negedge clk); hs = wready;
      @(posedge clk); #1;
      n++;
      if (!hs && n > 50) begin timeout_fail("w_handshake"); break; end
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  // Beat i carries data0+i; WLAST is driven on beat wlast_beat only.
  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [31:0] data0, input logic [3:0] strb,
                             input int wlast_beat, input logic [1:0] exp_resp);
    bq.push_back('{id: id, resp: exp_resp});
    do_aw(id, addr, len, burst);
    for (int i = 0; i <= int'(len); i++) do_w(data0 + 32'(i), strb, i == wlast_beat);
  endtask

  task automatic push_r(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                        input logic last);
    rq.push_back('{id: id, data: data, resp: resp, last: last});
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (rq.size() != 0 || bq.size() != 0) begin
      timeout_fail("drain");
      rq.delete();
      bq.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awburst = AXI_BURST_INCR;
    arid = '0; araddr = '0; arlen = '0; arburst = AXI_BURST_INCR;
    wdata = '0; wstrb = '0; wlast = 1'b0;

    @(negedge clk);
    check_val("reset_awready", 32'(awready), 32'd0);
    check_val("reset_arready", 32'(arready), 32'd0);
    check_val("reset_wready",  32'(wready),  32'd0);
    check_val("reset_bvalid",  32'(bvalid),  32'd0);
    check_val("reset_rvalid",  32'(rvalid),  32'd0);
    check_val("reset_rdata",   rdata,        32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // INCR write then read back
    write_burst(4'h5, 32'h10, 8'd3, AXI_BURST_INCR, 32'hA0, 4'hF, 3, AXI_RESP_OKAY);
    drain();
    for (int i = 0; i < 4; i++) push_r(4'h5, 32'hA0 + 32'(i), AXI_RESP_OKAY, i == 3);
    do_ar(4'h5, 32'h10, 8'd3, AXI_BURST_INCR);
    drain();

    // byte-strobe merge
    write_burst(4'h1, 32'h40, 8'd0, AXI_BURST_INCR, 32'h12345678, 4'hF, 0, AXI_RESP_OKAY);
    write_burst(4'h2, 32'h40, 8'd0, AXI_BURST_INCR, 32'hFFFFFFFF, 4'b0101, 0, AXI_RESP_OKAY);
    drain();
    push_r(4'h2, 32'h12FF56FF, AXI_RESP_OKAY, 1'b1);
    do_ar(4'h2, 32'h40, 8'd0, AXI_BURST_INCR);
    drain();

    // 8-beat read with RREADY toggling
    write_burst(4'h3, 32'h100, 8'd7, AXI_BURST_INCR, 32'hB0, 4'hF, 7, AXI_RESP_OKAY);
    drain();
    rmode = 1;
    for (int i = 0; i < 8; i++) push_r(4'h3, 32'hB0 + 32'(i), AXI_RESP_OKAY, i == 7);
    do_ar(4'h3, 32'h100, 8'd7, AXI_BURST_INCR);
    drain();
    rmode = 0;

    // early WLAST (beat 1 of 4) and missing final WLAST -> SLVERR; data still written
    write_burst(4'h4, 32'h200, 8'd3, AXI_BURST_INCR, 32'hE0, 4'hF, 1, AXI_RESP_SLVERR);
    drain();
    for (int i = 0; i < 4; i++) push_r(4'h4, 32'hE0 + 32'(i), AXI_RESP_OKAY, i == 3);
    do_ar(4'h4, 32'h200, 8'd3, AXI_BURST_INCR);
    drain();

    // out-of-range accesses and a burst straddling the top of memory
    write_burst(4'h6, 32'h1000, 8'd0, AXI_BURST_INCR, 32'hDEAD0000, 4'hF, 0, AXI_RESP_DECERR);
    write_burst(4'h7, 32'hFFC, 8'd1, AXI_BURST_INCR, 32'hD0, 4'hF, 1, AXI_RESP_DECERR);
    drain();
    push_r(4'h6, 32'h0, AXI_RESP_DECERR, 1'b1);
    do_ar(4'h6, 32'h1000, 8'd0, AXI_BURST_INCR);
    drain();
    push_r(4'h7, 32'hD0, AXI_RESP_OKAY, 1'b0);
    push_r(4'h7, 32'h0, AXI_RESP_DECERR, 1'b1);
    do_ar(4'h7, 32'hFFC, 8'd1, AXI_BURST_INCR);
    drain();

    // reset in the middle of a stalled read burst
    rmode = 2;
    do_ar(4'h8, 32'h100, 8'd7, AXI_BURST_INCR);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("midburst_rvalid", 32'(rvalid), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check_val("rst_rvalid",  32'(rvalid),  32'd0);
    check_val("rst_arready", 32'(arready), 32'd0);
    rq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; rmode = 0;
    for (int i = 0; i < 4; i++) push_r(4'h9, 32'hA0 + 32'(i), AXI_RESP_OKAY, i == 3);
    do_ar(4'h9, 32'h10, 8'd3, AXI_BURST_INCR);
    drain();

`ifdef AXI_SLAVE_WRAP_BURST_EN
    // WRAP from 0x18: beats land at 0x18, 0x1C, 0x10, 0x14
    write_burst(4'hA, 32'h18, 8'd3, AXI_BURST_WRAP, 32'hC0, 4'hF, 3, AXI_RESP_OKAY);
    drain();
    push_r(4'hA, 32'hC2, AXI_RESP_OKAY, 1'b0);
    push_r(4'hA, 32'hC3, AXI_RESP_OKAY, 1'b0);
    push_r(4'hA, 32'hC0, AXI_RESP_OKAY, 1'b0);
    push_r(4'hA, 32'hC1, AXI_RESP_OKAY, 1'b1);
    do_ar(4'hA, 32'h10, 8'd3, AXI_BURST_INCR);
    drain();
    write_burst(4'hB, 32'h400, 8'd2, AXI_BURST_WRAP, 32'hF0, 4'hF, 2, AXI_RESP_SLVERR);
    drain();
`else
    // WRAP behaves as INCR when the option is off
    write_burst(4'hA, 32'h18, 8'd3, AXI_BURST_WRAP, 32'hC0, 4'hF, 3, AXI_RESP_OKAY);
    drain();
    for (int i = 0; i < 4; i++) push_r(4'hA, 32'hC0 + 32'(i), AXI_RESP_OKAY, i == 3);
    do_ar(4'hA, 32'h18, 8'd3, AXI_BURST_INCR);
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish required completion");
    $fatal(1, "watchdog");
  end

endmodule
